uart_expr_parser: RTL
=====================

UART_EXPR_PARSER -- requirements
Module: uart_expr_parser

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received ASCII byte from the UART receiver
- rx_done  input  1  one-cycle strobe; rx_data valid this cycle
- alu_done  input  1  one-cycle strobe from the arithmetic stage; result consumed
- Q  output  4  first operand (dividend for '/')
- M  output  4  second operand (divisor for '/')
- op  output  2  operator code: 00 '+', 01 '-', 10 '*', 11 '/'
- parser_done  output  1  one-cycle strobe; Q, M and op are valid and stable
- busy  output  1  high from the parser_done strobe until alu_done
- err  output  1  one-cycle strobe on a syntax error

Function
REQ-003 The block SHALL accept expressions of the form "A op B =", where A and B are single hex digits and op is one of '+', '-', '*', '/'.
REQ-004 The hex digits '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) SHALL map to the values 0-15.
REQ-005 The terminators '=' (0x3D) and CR (0x0D) SHALL be treated as equivalent.
REQ-006 Space (0x20) SHALL be ignored in every state and SHALL NOT change state or outputs.
REQ-007 The state machine SHALL have the states WAIT_A, WAIT_OP, WAIT_B, WAIT_EQ, DONE and BUSY; reset state WAIT_A.
REQ-008 In WAIT_A, a valid digit on rx_done SHALL load the digit into Q and move the FSM to WAIT_OP.
REQ-009 In WAIT_OP, a valid operator on rx_done SHALL load op and move the FSM to WAIT_B.
REQ-010 In WAIT_B, a valid digit on rx_done SHALL load the digit into M and move the FSM to WAIT_EQ.
REQ-011 In WAIT_EQ, a terminator on rx_done SHALL move the FSM to DONE.
REQ-012 DONE SHALL last exactly one cycle, assert parser_done for that cycle only, and move the FSM to BUSY.
- Latency: parser_done is high in the cycle after the terminator's rx_done cycle.
REQ-013 BUSY SHALL hold busy=1 and keep Q, M and op stable, then return to WAIT_A on the cycle after alu_done=1.
REQ-014 In BUSY, rx_done bytes SHALL be discarded, with no err strobe and no change to any output.
REQ-015 In WAIT_A through WAIT_EQ, any other byte (not a space and not the expected class) SHALL pulse err for one cycle, in the cycle after rx_done, and return the FSM to WAIT_A.
- On this error Q, M and op retain their last values.
REQ-016 A digit arriving in WAIT_OP or WAIT_EQ SHALL be an error, not an overwrite; multi-digit operands are not supported.
REQ-017 alu_done outside BUSY SHALL be ignored.
REQ-018 If alu_done and rx_done are both high in the same BUSY cycle, the byte SHALL be discarded and the FSM SHALL return to WAIT_A.
REQ-019 The outputs parser_done, err and busy SHALL be registered, and parser_done and err SHALL never be high in the same cycle.
REQ-020 Q and M SHALL change only on a digit-accept cycle, and op SHALL change only on an operator-accept cycle.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL set Q=0, M=0, op=00, parser_done=0, busy=0, err=0 and state WAIT_A.
REQ-022 Reset SHALL take priority over rx_done and alu_done in the same cycle.
REQ-023 Reset mid-expression or in BUSY SHALL abandon the expression with no parser_done or err strobe.

Verification
REQ-024 Bytes '7','/','2','=' -> one parser_done pulse with Q=7, M=2, op=11, then busy=1; alu_done 20 cycles later -> busy=0 and state WAIT_A.
REQ-025 Bytes 'a',' ','*',' ','F',CR -> parser_done with Q=10, M=15, op=10; no err pulse.
REQ-026 Bytes '5','5' -> err pulse after the second byte and state WAIT_A; Q stays 5; then '5','-','5','=' -> parser_done with Q=5, M=5, op=01.
REQ-027 While BUSY, bytes '3','+','4','=' -> no parser_done, no err, and Q, M, op unchanged; after alu_done, a fresh expression parses normally.
REQ-028 rst=1 after '9','+' -> all outputs at reset values; a following '1','=' produces err (the '=' is not a valid operator), not parser_done.
REQ-029 Bytes 'G' (0x47) and then '+' in WAIT_A -> an err pulse for each byte; rx_done together with alu_done in BUSY -> WAIT_A, byte dropped.

Source files
------------

// File: rtl/uart_expr_parser.sv
// ============================================================================
//  Module      : uart_expr_parser
//  Description : Parses "A op B =" hex-digit expressions from a UART byte
//                stream and hands operands/operator to an arithmetic stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_expr_parser (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       alu_done,
    output logic [3:0] Q,
    output logic [3:0] M,
    output logic [1:0] op,
    output logic       parser_done,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] c_WAIT_A  = 3'd0;
    localparam logic [2:0] c_WAIT_OP = 3'd1;
    localparam logic [2:0] c_WAIT_B  = 3'd2;
    localparam logic [2:0] c_WAIT_EQ = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;
    localparam logic [2:0] c_BUSY    = 3'd5;

    logic [2:0] r_state;
    logic [3:0] r_q;
    logic [3:0] r_m;
    logic [1:0] r_op;
    logic       r_parser_done;
    logic       r_busy;
    logic       r_err;

    logic       w_is_digit;
    logic [3:0] w_digit_val;
    logic       w_is_op;
    logic [1:0] w_op_code;
    logic       w_is_term;
    logic       w_is_space;

    // Letter digits: low nibble of 'A'/'a' is 1, so adding 9 yields 10.
    always_comb begin
        w_is_digit  = 1'b1;
        w_digit_val = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_digit_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            w_digit_val = rx_data[3:0] + 4'd9;
        end else begin
            w_is_digit = 1'b0;
        end
    end

    always_comb begin
        w_is_op   = 1'b1;
        w_op_code = 2'b00;
        case (rx_data)
            8'h2B:   w_op_code = 2'b00;
            8'h2D:   w_op_code = 2'b01;
            8'h2A:   w_op_code = 2'b10;
            8'h2F:   w_op_code = 2'b11;
            default: w_is_op   = 1'b0;
        endcase
    end

    assign w_is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    assign w_is_space = (rx_data == 8'h20);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_WAIT_A;
            r_q           <= 4'd0;
            r_m           <= 4'd0;
            r_op          <= 2'b00;
            r_parser_done <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_parser_done <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                c_WAIT_A: begin
                    if (rx_done && !w_is_space) begin
                        if (w_is_digit) begin
                            r_q     <= w_digit_val;
                            r_state <= c_WAIT_OP;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_WAIT_A;
                        end
                    end
                end
                c_WAIT_OP: begin
                    if (rx_done && !w_is_space) begin
                        if (w_is_op) begin
                            r_op    <= w_op_code;
                            r_state <= c_WAIT_B;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_WAIT_A;
                        end
                    end
                end
                c_WAIT_B: begin
                    if (rx_done && !w_is_space) begin
                        if (w_is_digit) begin
                            r_m     <= w_digit_val;
                            r_state <= c_WAIT_EQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_WAIT_A;
                        end
                    end
                end
                c_WAIT_EQ: begin
                    if (rx_done && !w_is_space) begin
                        if (w_is_term) begin
                            r_parser_done <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= c_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_WAIT_A;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_BUSY;
                end
                c_BUSY: begin
                    // Incoming bytes are dropped while the ALU owns the operands.
                    if (alu_done) begin
                        r_busy  <= 1'b0;
                        r_state <= c_WAIT_A;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_WAIT_A;
                end
            endcase
        end
    end

    assign Q           = r_q;
    assign M           = r_m;
    assign op          = r_op;
    assign parser_done = r_parser_done;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule

`default_nettype wire
